// File: rtl/io_byte_sequencer.sv
// Serialises io_core word/half/byte requests onto a byte-wide ready/valid UART link and
// reassembles received bytes into a zero-extended word; one request in flight at a time.
module io_byte_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        io_flag,
  input  logic        io_write_flag,
  input  logic [1:0]  io_size,
  input  logic [31:0] io_i_data,
  output logic [31:0] io_o_data,
  output logic        io_accessed,
  output logic        io_error,
  output logic        busy,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        rx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_e;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e            state_q,       state_d;
  logic [31:0]       buf_q,         buf_d;
  logic [1:0]        idx_q,         idx_d;
  logic [1:0]        last_q,        last_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic [31:0]       io_o_data_q,   io_o_data_d;
  logic              io_accessed_q, io_accessed_d;
  logic              io_error_q,    io_error_d;
  logic              tx_valid_q,    tx_valid_d;
  logic [7:0]        tx_data_q,     tx_data_d;
  logic              rx_ready_q,    rx_ready_d;

  logic              tx_fire;
  logic              rx_fire;
  logic              stall_expired;
  logic [1:0]        idx_inc;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    idx_d         = idx_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    io_o_data_d   = io_o_data_q;
    io_accessed_d = 1'b0;
    io_error_d    = 1'b0;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    rx_ready_d    = rx_ready_q;

    tx_fire       = tx_valid_q & tx_ready;
    rx_fire       = rx_ready_q & rx_valid;
    idx_inc       = idx_q + 2'd1;
    stall_expired = TO_EN && (cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (io_flag) begin
          idx_d  = '0;
          cnt_d  = '0;
          last_d = (io_size == 2'd0) ? 2'd0 : (io_size == 2'd1) ? 2'd1 : 2'd3;
          if (io_write_flag) begin
            buf_d      = io_i_data;
            tx_valid_d = 1'b1;
            tx_data_d  = io_i_data[7:0];
            state_d    = S_WRITE;
          end else begin
            // Cleared so bytes never received read back as zero.
            buf_d      = '0;
            rx_ready_d = 1'b1;
            state_d    = S_READ;
          end
        end
      end

      S_WRITE: begin
        if (tx_fire) begin
          cnt_d = '0;
          idx_d = idx_inc;
          if (idx_q == last_q) begin
            tx_valid_d    = 1'b0;
            io_accessed_d = 1'b1;
            state_d       = S_DONE;
          end else begin
            tx_data_d = buf_q[{idx_inc, 3'b000} +: 8];
          end
        end else if (stall_expired) begin
          tx_valid_d    = 1'b0;
          io_accessed_d = 1'b1;
          io_error_d    = 1'b1;
          state_d       = S_DONE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_READ: begin
        if (rx_fire) begin
          cnt_d                          = '0;
          idx_d                          = idx_inc;
          buf_d[{idx_q, 3'b000} +: 8]    = rx_data;
          if (idx_q == last_q) begin
            rx_ready_d    = 1'b0;
            io_o_data_d   = buf_d;
            io_accessed_d = 1'b1;
            state_d       = S_DONE;
          end
        end else if (stall_expired) begin
          // Partial fill is still published so the caller sees what did arrive.
          rx_ready_d    = 1'b0;
          io_o_data_d   = buf_q;
          io_accessed_d = 1'b1;
          io_error_d    = 1'b1;
          state_d       = S_DONE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      idx_q         <= '0;
      last_q        <= '0;
      cnt_q         <= '0;
      io_o_data_q   <= '0;
      io_accessed_q <= 1'b0;
      io_error_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      rx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      io_o_data_q   <= io_o_data_d;
      io_accessed_q <= io_accessed_d;
      io_error_q    <= io_error_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      rx_ready_q    <= rx_ready_d;
    end
  end

  assign io_o_data   = io_o_data_q;
  assign io_accessed = io_accessed_q;
  assign io_error    = io_error_q;
  assign busy        = (state_q != S_IDLE);
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign rx_ready    = rx_ready_q;

endmodule

// File: tb/tb_io_byte_sequencer.sv
// Scoreboard bench for io_byte_sequencer: requests push expected completions and TX bytes,
// independent monitor/sink/source processes compare against what the DUT presents.
module tb_io_byte_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        io_flag;
  logic        io_write_flag;
  logic [1:0]  io_size;
  logic [31:0] io_i_data;
  logic [31:0] io_o_data;
  logic        io_accessed;
  logic        io_error;
  logic        busy;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_ready;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;

  always #5 clk = ~clk;

  io_byte_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(24)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .io_flag      (io_flag),
    .io_write_flag(io_write_flag),
    .io_size      (io_size),
    .io_i_data    (io_i_data),
    .io_o_data    (io_o_data),
    .io_accessed  (io_accessed),
    .io_error     (io_error),
    .busy         (busy),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_ready     (rx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          err;
    int          exp_cyc;
  } resp_t;

  int          n_checks    = 0;
  int          n_fail      = 0;
  int          n_expected  = 0;
  int          n_accessed  = 0;
  int          cyc         = 0;
  resp_t       sb_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_src_q[$];
  logic [31:0] model_rdata = 32'h0;

  int          sink_hold   = 0;
  bit          sink_random = 1'b0;
  int          sink_zeros  = 0;
  bit          tx_stalled  = 1'b0;
  logic [7:0]  tx_prev     = 8'h00;
  bit          src_random  = 1'b0;
  int          src_zeros   = 0;
  resp_t       mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      check("tx_valid_rx_ready_exclusive", 32'(tx_valid & rx_ready), 32'd0);
      if (io_accessed) begin
        n_accessed++;
        if (sb_q.size() == 0) begin
          check("unexpected_io_accessed", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("io_error", 32'(io_error), 32'(mon_e.err));
          check("io_o_data", io_o_data, mon_e.data);
          check("busy_in_done", 32'(busy), 32'd1);
          if (mon_e.exp_cyc >= 0) check("completion_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
        end
      end
    end
  end

  // TX sink: takes bytes, optionally stalls, checks order and stability.
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      tx_ready   = 1'b0;
      tx_stalled = 1'b0;
    end else if (tx_valid) begin
      if (tx_stalled) check("tx_data_stable", 32'(tx_data), 32'(tx_prev));
      if (sink_hold > 0) begin
        tx_ready = 1'b0;
        sink_hold--;
      end else if (sink_random && sink_zeros < 3 && $urandom_range(0, 2) == 0) begin
        tx_ready = 1'b0;
      end else begin
        tx_ready = 1'b1;
      end
      sink_zeros = tx_ready ? 0 : sink_zeros + 1;
      if (tx_ready) begin
        tx_stalled = 1'b0;
        if (tx_exp_q.size() == 0) check("unexpected_tx_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else                      check("tx_byte", 32'(tx_data), 32'(tx_exp_q.pop_front()));
      end else begin
        tx_stalled = 1'b1;
        tx_prev    = tx_data;
      end
    end else begin
      tx_ready   = 1'($urandom_range(0, 1));
      tx_stalled = 1'b0;
    end
  end

  // RX source: offers queued bytes while the DUT is ready, junk otherwise.
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end else if (rx_ready) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      if (rx_src_q.size() != 0) begin
        if (src_random && src_zeros < 3 && $urandom_range(0, 2) == 0) begin
          src_zeros++;
        end else begin
          src_zeros = 0;
          rx_valid  = 1'b1;
          rx_data   = rx_src_q.pop_front();
        end
      end
    end else begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one request; for reads, data supplies the bytes fed (only nfeed of them).
  task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] data,
                       input int nfeed, input bit timed, input int hold, input bit repulse);
    int          nb;
    int          lat;
    resp_t       e;
    logic [31:0] word;
    nb        = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    word      = 32'h0;
    e.is_read = !wr;
    e.err     = 1'b0;
    if (wr) begin
      for (int i = 0; i < nb; i++) tx_exp_q.push_back(data[8*i +: 8]);
      e.data    = model_rdata;
      sink_hold = hold;
    end else begin
      for (int i = 0; i < nfeed && i < nb; i++) begin
        rx_src_q.push_back(data[8*i +: 8]);
        word[8*i +: 8] = data[8*i +: 8];
      end
      e.err       = (nfeed < nb);
      model_rdata = word;
      e.data      = word;
    end
    lat       = e.err ? nfeed + TO : nb + hold;
    e.exp_cyc = timed ? cyc + 1 + lat : -1;
    sb_q.push_back(e);
    n_expected++;
    io_flag       = 1'b1;
    io_write_flag = wr;
    io_size       = size;
    io_i_data     = wr ? data : $urandom;
    @(negedge clk);
    io_flag = 1'b0;
    if (repulse) begin
      io_flag       = 1'b1;
      io_write_flag = !wr;
      io_size       = 2'd3;
      io_i_data     = ~data;
      @(negedge clk);
      io_flag = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_io_o_data"},   io_o_data,            32'h0);
    check({tag, "_io_accessed"}, 32'(io_accessed),     32'd0);
    check({tag, "_io_error"},    32'(io_error),        32'd0);
    check({tag, "_busy"},        32'(busy),            32'd0);
    check({tag, "_tx_valid"},    32'(tx_valid),        32'd0);
    check({tag, "_tx_data"},     32'(tx_data),         32'd0);
    check({tag, "_rx_ready"},    32'(rx_ready),        32'd0);
  endtask

  initial begin
    rstn          = 1'b0;
    io_flag       = 1'b0;
    io_write_flag = 1'b0;
    io_size       = 2'd0;
    io_i_data     = 32'h0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Directed cases with exact timing.
    issue(1'b1, 2'd2, 32'h1122_3344, 0, 1'b1, 0, 1'b0);
    issue(1'b0, 2'd1, 32'h0000_CDAB, 2, 1'b1, 0, 1'b0);
    check("rx_ready_low_after_read", 32'(rx_ready), 32'd0);
    issue(1'b1, 2'd0, 32'h0000_005A, 0, 1'b1, 5, 1'b0);
    issue(1'b1, 2'd2, 32'hDEAD_BEEF, 0, 1'b1, 0, 1'b1);
    issue(1'b0, 2'd2, 32'h0,         0, 1'b1, 0, 1'b0);
    issue(1'b0, 2'd1, 32'h0000_9C3E, 1, 1'b1, 0, 1'b0);
    issue(1'b1, 2'd1, 32'hCAFE_F00D, 0, 1'b1, 0, 1'b0);
    issue(1'b0, 2'd3, 32'h8765_4321, 4, 1'b1, 0, 1'b0);

    // Reset in the middle of a 4-byte read after two bytes.
    rx_src_q.push_back(8'h12);
    rx_src_q.push_back(8'h34);
    io_flag       = 1'b1;
    io_write_flag = 1'b0;
    io_size       = 2'd2;
    io_i_data     = $urandom;
    @(negedge clk);
    io_flag = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_rdata = 32'h0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(1'b0, 2'd0, 32'h0000_007F, 1, 1'b1, 0, 1'b0);

    // Randomised traffic with back-pressure on both sides.
    sink_random = 1'b1;
    src_random  = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [1:0] sz;
      bit         wr;
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      issue(wr, sz, $urandom, 4, 1'b0, 0, 1'($urandom_range(0, 3) == 0));
    end
    sink_random = 1'b0;
    src_random  = 1'b0;
    for (int n = 0; n < 6; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 4, 1'b1, 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained",  32'(sb_q.size()),     32'd0);
    check("tx_bytes_drained",    32'(tx_exp_q.size()), 32'd0);
    check("io_accessed_count",   32'(n_accessed),      32'(n_expected));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
